// File: rtl/gam_seq_alu_if.sv
// gam_seq_alu_if: valid/ready operand and result bus for the GAM sequential ALU.
// master drives operands and out_ready; slave is the ALU.
interface gam_seq_alu_if #(
   parameter int WIDTH = 8
);
   logic                 in_valid;
   logic                 in_ready;
   logic [2:0]           op;
   logic [WIDTH-1:0]     a;
   logic [WIDTH-1:0]     b;
   logic                 out_valid;
   logic                 out_ready;
   logic [2*WIDTH-1:0]   result;
   logic                 ovf;
   logic                 div_zero;
   logic                 op_err;
   modport master (
      output in_valid, op, a, b, out_ready,
      input  in_ready, out_valid, result, ovf, div_zero, op_err
   );
   modport slave (
      input  in_valid, op, a, b, out_ready,
      output in_ready, out_valid, result, ovf, div_zero, op_err
   );
endinterface

// File: rtl/gam_seq_alu.sv
// gam_seq_alu: sequential signed ALU; ADD/SUB/ABSDIFF/MUL in one cycle, DIV/SQRT one bit per cycle.
// Optional macro GAM_ALU_SAT_EN: ADD/SUB saturate instead of wrapping.
module gam_seq_alu #(
   parameter int WIDTH = 8
) (
   input logic          clk,
   input logic          rst,
   gam_seq_alu_if.slave bus
);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] DONE = 2'd2;
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] DIV_N = CW'(WIDTH);
   localparam logic [CW-1:0] SQ_N = CW'(WIDTH / 2);

   logic [1:0]         state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [WIDTH+1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]   sh_q, sh_d, qr_q, qr_d, dvs_q, dvs_d;
   logic               neg_q, neg_d, sq_q, sq_d;
   logic               ovf_q, ovf_d, dz_q, dz_d, err_q, err_d;
   logic [2*WIDTH-1:0] res_q, res_d;

   logic [WIDTH:0]     sum_w, dif_w, abs_w, arith_w, qs_w;
   logic [WIDTH-1:0]   am_w, bm_w, as_w, qn_w;
   logic [2*WIDTH-1:0] mul_w;
   logic [WIDTH+1:0]   r_w, t_w;
   logic               ao_w, ge_w;

   assign sum_w   = {bus.a[WIDTH-1], bus.a} + {bus.b[WIDTH-1], bus.b};
   assign dif_w   = {bus.a[WIDTH-1], bus.a} - {bus.b[WIDTH-1], bus.b};
   assign abs_w   = dif_w[WIDTH] ? -dif_w : dif_w;
   assign arith_w = bus.op[0] ? dif_w : sum_w;
   assign ao_w    = arith_w[WIDTH] ^ arith_w[WIDTH-1];
`ifdef GAM_ALU_SAT_EN
   assign as_w = ao_w ? {arith_w[WIDTH], {(WIDTH-1){~arith_w[WIDTH]}}} : arith_w[WIDTH-1:0];
`else
   assign as_w = arith_w[WIDTH-1:0];
`endif
   assign mul_w = $signed({{WIDTH{bus.a[WIDTH-1]}}, bus.a}) * $signed({{WIDTH{bus.b[WIDTH-1]}}, bus.b});
   assign am_w  = bus.a[WIDTH-1] ? -bus.a : bus.a;
   assign bm_w  = bus.b[WIDTH-1] ? -bus.b : bus.b;

   // One restoring step: DIV brings in one dividend bit, SQRT two radicand bits against trial 4*root+1.
   assign r_w  = (sq_q ? acc_q << 2 : acc_q << 1)
               | {{WIDTH{1'b0}}, sq_q ? sh_q[WIDTH-1:WIDTH-2] : {1'b0, sh_q[WIDTH-1]}};
   assign t_w  = sq_q ? {qr_q, 2'b01} : {2'b00, dvs_q};
   assign ge_w = r_w >= t_w;
   assign qn_w = {qr_q[WIDTH-2:0], ge_w};
   assign qs_w = neg_q ? -{1'b0, qn_w} : {1'b0, qn_w};

   assign bus.in_ready  = (state_q == IDLE) && !rst;
   assign bus.out_valid = state_q == DONE;
   assign bus.result    = res_q;
   assign bus.ovf       = ovf_q;
   assign bus.div_zero  = dz_q;
   assign bus.op_err    = err_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      sh_d    = sh_q;
      qr_d    = qr_q;
      dvs_d   = dvs_q;
      neg_d   = neg_q;
      sq_d    = sq_q;
      res_d   = res_q;
      ovf_d   = ovf_q;
      dz_d    = dz_q;
      err_d   = err_q;
      if (state_q == IDLE && bus.in_valid) begin
         state_d = DONE;
         acc_d   = '0;
         qr_d    = '0;
         dvs_d   = bm_w;
         neg_d   = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
         sq_d    = bus.op[0];
         case (bus.op)
            3'd0, 3'd1: begin
               res_d = {{WIDTH{as_w[WIDTH-1]}}, as_w};
               ovf_d = ao_w;
            end
            3'd2: res_d = {{(WIDTH-1){1'b0}}, abs_w};
            3'd3: res_d = mul_w;
            3'd4: begin
               dz_d    = bus.b == '0;
               state_d = bus.b == '0 ? DONE : BUSY;
               cnt_d   = DIV_N;
               sh_d    = am_w;
            end
            3'd5: begin
               err_d   = bus.a[WIDTH-1];
               state_d = bus.a[WIDTH-1] ? DONE : BUSY;
               cnt_d   = SQ_N;
               sh_d    = bus.a;
            end
            default: err_d = 1'b1;
         endcase
      end else if (state_q == BUSY) begin
         acc_d = ge_w ? r_w - t_w : r_w;
         sh_d  = sq_q ? sh_q << 2 : sh_q << 1;
         qr_d  = qn_w;
         cnt_d = cnt_q - 1'b1;
         if (cnt_q == CW'(1)) begin
            state_d = DONE;
            res_d   = sq_q ? {{WIDTH{1'b0}}, qn_w} : {{(WIDTH-1){qs_w[WIDTH]}}, qs_w};
         end
      end else if (state_q == DONE && bus.out_ready) begin
         state_d = IDLE;
         cnt_d   = '0;
         res_d   = '0;
         ovf_d   = 1'b0;
         dz_d    = 1'b0;
         err_d   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         sh_q    <= '0;
         qr_q    <= '0;
         dvs_q   <= '0;
         neg_q   <= 1'b0;
         sq_q    <= 1'b0;
         res_q   <= '0;
         ovf_q   <= 1'b0;
         dz_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         sh_q    <= sh_d;
         qr_q    <= qr_d;
         dvs_q   <= dvs_d;
         neg_q   <= neg_d;
         sq_q    <= sq_d;
         res_q   <= res_d;
         ovf_q   <= ovf_d;
         dz_q    <= dz_d;
         err_q   <= err_d;
      end
   end
endmodule

// File: tb/tb_gam_seq_alu.sv
// tb_gam_seq_alu: directed and random transactions against an integer reference model.
// Define GAM_ALU_SAT_EN for both DUT and bench to check the saturating build.
module tb_gam_seq_alu;
   localparam int W = 8;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int checks = 0;
   int errors = 0;

   gam_seq_alu_if #(.WIDTH(W)) bus ();
   gam_seq_alu #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   function automatic void model(input int o, input int sa, input int sb,
                                 output logic [2*W-1:0] r, output logic [2:0] f, output int l);
      int s, q, hi, lo;
      logic [W-1:0] t;
      hi = (1 << (W - 1)) - 1;
      lo = -(1 << (W - 1));
      r = '0;
      f = 3'b000;
      l = 1;
      case (o)
         0, 1: begin
            s = (o == 0) ? sa + sb : sa - sb;
            f[2] = (s > hi) || (s < lo);
`ifdef GAM_ALU_SAT_EN
            s = (s > hi) ? hi : (s < lo) ? lo : s;
`endif
            t = s[W-1:0];
            r = {{W{t[W-1]}}, t};
         end
         2: r = (2*W)'((sa > sb) ? sa - sb : sb - sa);
         3: r = (2*W)'(sa * sb);
         4: if (sb == 0) f[1] = 1'b1;
            else begin
               r = (2*W)'(sa / sb);
               l = W + 1;
            end
         5: if (sa < 0) f[0] = 1'b1;
            else begin
               q = 0;
               while ((q + 1) * (q + 1) <= sa) q++;
               r = (2*W)'(q);
               l = W / 2 + 1;
            end
         default: f[0] = 1'b1;
      endcase
   endfunction

   task automatic run(input string tag, input int o, input int av, input int bv, input int hold);
      logic [2*W-1:0] er;
      logic [2:0] ef;
      int el, lat;
      logic [W-1:0] ab, bb;
      ab = av[W-1:0];
      bb = bv[W-1:0];
      model(o, int'($signed(ab)), int'($signed(bb)), er, ef, el);
      @(negedge clk);
      chk({tag, "/in_ready"}, 32'(bus.in_ready), 1);
      bus.in_valid  = 1'b1;
      bus.op        = o[2:0];
      bus.a         = ab;
      bus.b         = bb;
      bus.out_ready = (hold == 0);
      @(posedge clk);
      #1;
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.op       = 3'($urandom);
      bus.a        = W'($urandom);
      bus.b        = W'($urandom);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!bus.out_valid && lat < 40);
      bus.in_valid = 1'b0;
      chk({tag, "/latency"}, 32'(lat), 32'(el));
      chk({tag, "/result"}, 32'(bus.result), 32'(er));
      chk({tag, "/flags"}, 32'({bus.ovf, bus.div_zero, bus.op_err}), 32'(ef));
      repeat (hold) begin
         chk({tag, "/hold_valid"}, 32'(bus.out_valid), 1);
         chk({tag, "/hold_result"}, 32'(bus.result), 32'(er));
         chk({tag, "/hold_in_ready"}, 32'(bus.in_ready), 0);
         @(negedge clk);
      end
      bus.out_ready = 1'b1;
      chk({tag, "/handoff_in_ready"}, 32'(bus.in_ready), 0);
      @(negedge clk);
      chk({tag, "/idle"}, 32'({bus.out_valid, bus.in_ready, bus.ovf, bus.div_zero, bus.op_err}),
          32'(5'b01000));
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.op        = '0;
      bus.a         = '0;
      bus.b         = '0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("reset/in_ready", 32'(bus.in_ready), 0);
      chk("reset/out_valid", 32'(bus.out_valid), 0);
      chk("reset/result", 32'(bus.result), 0);
      rst = 1'b0;
      run("add_ovf", 0, 100, 50, 0);
      run("add_max", 0, 127, 0, 1);
      run("sub_ovf", 1, -128, 1, 0);
      run("sub_ok", 1, -100, 27, 0);
      run("mul_min", 3, -128, -128, 0);
      run("absdiff", 2, -128, 127, 0);
      run("div_neg", 4, -7, 2, 0);
      run("div_zero", 4, 5, 0, 0);
      run("div_minneg", 4, -128, -1, 0);
      run("div_min1", 4, -128, 1, 2);
      run("sqrt_127", 5, 127, 0, 0);
      run("sqrt_neg", 5, -4, 0, 0);
      run("sqrt_zero", 5, 0, 0, 0);
      run("op7", 7, 3, 3, 0);
      run("op6", 6, 1, 2, 0);
      run("mul_bp", 3, 3, 4, 5);
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.op       = 3'd4;
      bus.a        = W'(100);
      bus.b        = W'(3);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      chk("rst_mid/in_ready", 32'(bus.in_ready), 0);
      @(negedge clk);
      chk("rst_mid/out_valid", 32'(bus.out_valid), 0);
      chk("rst_mid/result", 32'(bus.result), 0);
      rst = 1'b0;
      run("div_after_rst", 4, 100, 3, 0);
      for (int i = 0; i < 80; i++)
         run("rand", int'($urandom_range(0, 7)), int'($urandom),
             ($urandom_range(0, 9) == 0) ? 0 : int'($urandom), int'($urandom_range(0, 2)));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
